sdram_memtest: RTL and testbench
================================

SDRAM_MEMTEST -- requirements
Module: sdram_memtest

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, word-address width tested (2^ADDR_W words).
REQ-002 SHALL have parameter DATA_W, default 8, data width, legal range 1..16.
REQ-003 SHALL have parameter TMO, default 255, maximum cycles from read request to read data.
REQ-004 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have ports: reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: start  in  1  pulse, begin a test when idle.
REQ-007 SHALL have ports: mode  in  2  pattern: 0 address, 1 inverted address, 2 LFSR, 3 checkerboard.
REQ-008 SHALL have ports: passes  in  8  pass count, 0 = run until reset.
REQ-009 SHALL have ports: slot  in  1  controller access slot enable; a request may issue only when 1.
REQ-010 SHALL have ports: mem_we / mem_oe  out  1 each  one-cycle write / read request.
REQ-011 SHALL have ports: mem_addr  out  ADDR_W; mem_din  out  DATA_W; mem_dout  in  DATA_W; mem_rvalid  in  1  read data valid.
REQ-012 SHALL have ports: busy, done, fail, timeout  out  1 each; err_count  out  16; first_err_addr  out  ADDR_W; first_err_got, first_err_exp  out  DATA_W each; pass_count  out  8.

Function
REQ-013 SHALL implement FSM IDLE -> WRITE -> READ -> WAIT_RD -> (READ | NEXT) -> (WRITE | DONE).
REQ-014 IDLE: start=1 SHALL latch mode and passes, clear err_count, done, fail, timeout and pass_count, zero the address, and go to WRITE; start while busy SHALL be ignored.
REQ-015 WRITE: on a cycle with slot=1, SHALL assert mem_we for exactly that cycle with mem_addr=addr and mem_din=pattern(addr), then increment addr; after the last address, SHALL wrap addr to 0 and go to READ.
REQ-016 READ: on a cycle with slot=1, SHALL assert mem_oe for one cycle, then go to WAIT_RD.
REQ-017 WAIT_RD: on mem_rvalid=1, SHALL compare mem_dout with pattern(addr); after the last address SHALL go to NEXT, otherwise SHALL increment addr and return to READ.
REQ-018 A mismatch SHALL set fail and saturating-increment err_count (holds at FFFF); on the first mismatch of a run only, SHALL capture addr, mem_dout and the expected value.
REQ-019 WAIT_RD: if no mem_rvalid arrives within TMO cycles, SHALL set timeout and fail and go to DONE.
REQ-020 mem_rvalid outside WAIT_RD SHALL be ignored.
REQ-021 NEXT: SHALL increment pass_count modulo 256; if passes!=0 and pass_count==passes, SHALL go to DONE, otherwise SHALL go to WRITE with addr=0.
REQ-022 DONE: SHALL hold done=1 and all results until the next start, which SHALL restart per REQ-014.
REQ-023 busy SHALL be 1 in every state except IDLE and DONE.
REQ-024 Pattern definitions, truncated or zero-extended to DATA_W: mode 0 = addr; mode 1 = ~addr; mode 3 = 0x5555 when addr[0]=0, else 0xAAAA; all modes SHALL XOR in pass_count[0] replicated (bit-inverting odd passes).
REQ-025 Mode 2 SHALL use a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) seeded with 16'hACE1 ^ {8'h00, pass_count} at the start of both WRITE and READ, stepped once per address; the pattern SHALL be its low DATA_W bits.

Reset
REQ-026 reset_n=0 SHALL asynchronously force IDLE, addr=0, and all outputs to 0, including during an outstanding read; in-flight read data SHALL be discarded.

Structure
REQ-027 A shared package SHALL hold the state enum, the mode encodings, the LFSR seed and tap constants, and the checkerboard constants.
REQ-028 SHALL have one sub-module memtest_pattern (mode, addr, pass_count, lfsr state -> pattern word); all other logic is flat.

Verification
REQ-029 Bench SHALL use ADDR_W=4, DATA_W=8, a behavioural memory with 2-cycle read latency, and slot toggling every 4 cycles.
REQ-030 mode=0, passes=1 -> 16 writes of 00..0F, 16 reads, done=1, fail=0, err_count=0, pass_count=1.
REQ-031 mode=2, passes=3, fault model forcing bit 3 stuck-at-1 at address 5 -> fail=1, first_err_addr=5, first_err_got = first_err_exp | 0x08, err_count = number of passes in which expected bit 3 was 0.
REQ-032 Memory never asserts mem_rvalid -> timeout=1, fail=1, done=1 after TMO+1 cycles in WAIT_RD.
REQ-033 passes=0, mode=3 -> pass_count wraps FF->00 with busy still 1; reset_n=0 mid-READ -> all outputs 0 immediately; a start after release runs cleanly.
REQ-034 Second start pulse while busy -> ignored, results unchanged; mem_we/mem_oe never high when slot=0 (assertion).

Source files
------------

// File: rtl/sdram_memtest_pkg.sv
// Shared definitions for the SDRAM memory tester: FSM encodings, pattern modes,
// LFSR and checkerboard constants.
package sdram_memtest_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WRITE   = 3'd1;
  localparam logic [2:0] ST_READ    = 3'd2;
  localparam logic [2:0] ST_WAIT_RD = 3'd3;
  localparam logic [2:0] ST_NEXT    = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  typedef enum logic [1:0] {
    MODE_ADDR = 2'd0,
    MODE_INV  = 2'd1,
    MODE_LFSR = 2'd2,
    MODE_CHK  = 2'd3
  } mode_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5
  localparam logic [15:0] LFSR_TAPS = 16'h002D;
  localparam logic [15:0] CHK_EVEN  = 16'h5555;
  localparam logic [15:0] CHK_ODD   = 16'hAAAA;

  function automatic logic [15:0] lfsr_step(input logic [15:0] state);
    return {^(state & LFSR_TAPS), state[15:1]};
  endfunction

  function automatic logic [15:0] lfsr_seed(input logic [7:0] pass_count);
    return LFSR_SEED ^ {8'h00, pass_count};
  endfunction

endpackage

// File: rtl/sdram_memtest_pattern.sv
// Test pattern generator: maps mode, address, pass number and LFSR state to the
// data word written and expected back.
module memtest_pattern
  import sdram_memtest_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        pass_count,
  input  logic [15:0]       lfsr,
  output logic [DATA_W-1:0] pattern
);

  localparam int EXT_W = (ADDR_W > 16) ? ADDR_W : 16;

  logic [ADDR_W-1:0] addr_inv_s;
  logic [EXT_W-1:0]  addr_ext_s;
  logic [EXT_W-1:0]  addr_inv_ext_s;
  logic [15:0]       chk_s;
  logic [DATA_W-1:0] base_s;

  // Invert before widening so the extension bits stay zero
  assign addr_inv_s     = ~addr;
  assign addr_ext_s     = EXT_W'(addr);
  assign addr_inv_ext_s = EXT_W'(addr_inv_s);
  assign chk_s          = addr[0] ? CHK_ODD : CHK_EVEN;

  // Select the raw pattern for the active mode
  always_comb begin
    base_s = '0;
    case (mode)
      MODE_ADDR: base_s = addr_ext_s[DATA_W-1:0];
      MODE_INV:  base_s = addr_inv_ext_s[DATA_W-1:0];
      MODE_LFSR: base_s = lfsr[DATA_W-1:0];
      MODE_CHK:  base_s = chk_s[DATA_W-1:0];
      default:   base_s = '0;
    endcase
  end

  assign pattern = base_s ^ {DATA_W{pass_count[0]}};

endmodule

// File: rtl/sdram_memtest.sv
// SDRAM memory tester: writes a pattern to every word, reads it back through the
// controller access slot, and records pass/fail, error count and first failure.
module sdram_memtest
  import sdram_memtest_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int TMO    = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [7:0]        passes,
  input  logic              slot,
  output logic              mem_we,
  output logic              mem_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic              mem_rvalid,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic              timeout,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_got,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [7:0]        pass_count
);

  localparam int TMO_W = $clog2(TMO + 2);

  logic [2:0]        state_r;
  logic [2:0]        state_nxt_s;
  logic [1:0]        mode_r;
  logic [7:0]        passes_r;
  logic [ADDR_W-1:0] addr_r;
  logic [15:0]       lfsr_r;
  logic [TMO_W-1:0]  tmo_cnt_r;
  logic              busy_r;
  logic              done_r;
  logic              fail_r;
  logic              timeout_r;
  logic [15:0]       err_count_r;
  logic [ADDR_W-1:0] first_err_addr_r;
  logic [DATA_W-1:0] first_err_got_r;
  logic [DATA_W-1:0] first_err_exp_r;
  logic [7:0]        pass_count_r;

  logic [DATA_W-1:0] pattern_s;
  logic              last_addr_s;
  logic              tmo_hit_s;
  logic              mismatch_s;
  logic [7:0]        pass_next_s;

  memtest_pattern #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_pattern (
    .mode       (mode_r),
    .addr       (addr_r),
    .pass_count (pass_count_r),
    .lfsr       (lfsr_r),
    .pattern    (pattern_s)
  );

  assign last_addr_s = (addr_r == {ADDR_W{1'b1}});
  assign tmo_hit_s   = (tmo_cnt_r == TMO_W'(TMO));
  assign mismatch_s  = (mem_dout != pattern_s);
  assign pass_next_s = pass_count_r + 8'd1;

  // Requests are gated by the live slot so they can never appear outside a slot cycle
  assign mem_we   = (state_r == ST_WRITE) && slot;
  assign mem_oe   = (state_r == ST_READ) && slot;
  assign mem_addr = addr_r;
  assign mem_din  = (state_r == ST_WRITE) ? pattern_s : {DATA_W{1'b0}};

  assign busy           = busy_r;
  assign done           = done_r;
  assign fail           = fail_r;
  assign timeout        = timeout_r;
  assign err_count      = err_count_r;
  assign first_err_addr = first_err_addr_r;
  assign first_err_got  = first_err_got_r;
  assign first_err_exp  = first_err_exp_r;
  assign pass_count     = pass_count_r;

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) state_nxt_s = ST_WRITE;
        else       state_nxt_s = state_r;
      end
      ST_WRITE: begin
        if (slot && last_addr_s) state_nxt_s = ST_READ;
        else                     state_nxt_s = ST_WRITE;
      end
      ST_READ: begin
        if (slot) state_nxt_s = ST_WAIT_RD;
        else      state_nxt_s = ST_READ;
      end
      ST_WAIT_RD: begin
        if (mem_rvalid)     state_nxt_s = last_addr_s ? ST_NEXT : ST_READ;
        else if (tmo_hit_s) state_nxt_s = ST_DONE;
        else                state_nxt_s = ST_WAIT_RD;
      end
      ST_NEXT: begin
        if ((passes_r != 8'd0) && (pass_next_s == passes_r)) state_nxt_s = ST_DONE;
        else                                                 state_nxt_s = ST_WRITE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register with busy/done flags decoded from the upcoming state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_DONE);
      done_r  <= (state_nxt_s == ST_DONE);
    end
  end

  // Address walk, LFSR, timeout counter and result capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_r           <= 2'd0;
      passes_r         <= 8'd0;
      addr_r           <= '0;
      lfsr_r           <= 16'h0000;
      tmo_cnt_r        <= '0;
      fail_r           <= 1'b0;
      timeout_r        <= 1'b0;
      err_count_r      <= 16'h0000;
      first_err_addr_r <= '0;
      first_err_got_r  <= '0;
      first_err_exp_r  <= '0;
      pass_count_r     <= 8'd0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            mode_r           <= mode;
            passes_r         <= passes;
            addr_r           <= '0;
            lfsr_r           <= lfsr_seed(8'd0);
            fail_r           <= 1'b0;
            timeout_r        <= 1'b0;
            err_count_r      <= 16'h0000;
            first_err_addr_r <= '0;
            first_err_got_r  <= '0;
            first_err_exp_r  <= '0;
            pass_count_r     <= 8'd0;
          end
        end
        ST_WRITE: begin
          if (slot) begin
            if (last_addr_s) begin
              addr_r <= '0;
              lfsr_r <= lfsr_seed(pass_count_r);
            end else begin
              addr_r <= addr_r + ADDR_W'(1);
              lfsr_r <= lfsr_step(lfsr_r);
            end
          end
        end
        ST_READ: begin
          if (slot) tmo_cnt_r <= '0;
        end
        ST_WAIT_RD: begin
          if (mem_rvalid) begin
            if (mismatch_s) begin
              fail_r <= 1'b1;
              if (err_count_r != 16'hFFFF) err_count_r <= err_count_r + 16'd1;
              // err_count only leaves zero on the first mismatch of a run
              if (err_count_r == 16'h0000) begin
                first_err_addr_r <= addr_r;
                first_err_got_r  <= mem_dout;
                first_err_exp_r  <= pattern_s;
              end
            end
            if (!last_addr_s) begin
              addr_r <= addr_r + ADDR_W'(1);
              lfsr_r <= lfsr_step(lfsr_r);
            end
          end else if (tmo_hit_s) begin
            timeout_r <= 1'b1;
            fail_r    <= 1'b1;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
          end
        end
        ST_NEXT: begin
          pass_count_r <= pass_next_s;
          lfsr_r       <= lfsr_seed(pass_next_s);
          addr_r       <= '0;
        end
        default: begin
          addr_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_memtest.sv
// Scoreboard bench for sdram_memtest: behavioural 2-cycle-latency memory with fault
// injection, reference model of the test patterns, and a decoupled output monitor.
module tb_sdram_memtest;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int TMO = 255;
  localparam int NADDR = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [7:0]    passes = 8'd0;
  logic          slot = 1'b0;
  logic          mem_we, mem_oe;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout = 8'h00;
  logic          mem_rvalid = 1'b0;
  logic          busy, done, fail, timeout;
  logic [15:0]   err_count;
  logic [AW-1:0] first_err_addr;
  logic [DW-1:0] first_err_got, first_err_exp;
  logic [7:0]    pass_count;

  sdram_memtest #(.ADDR_W(AW), .DATA_W(DW), .TMO(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .passes(passes),
    .slot(slot), .mem_we(mem_we), .mem_oe(mem_oe), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_rvalid(mem_rvalid),
    .busy(busy), .done(done), .fail(fail), .timeout(timeout),
    .err_count(err_count), .first_err_addr(first_err_addr),
    .first_err_got(first_err_got), .first_err_exp(first_err_exp),
    .pass_count(pass_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fail;
    logic        timeout;
    logic [15:0] err;
    logic [7:0]  pc;
    logic [3:0]  fa;
    logic [7:0]  fg;
    logic [7:0]  fe;
    int          lat;
  } res_t;

  logic [11:0] wr_q[$];
  int          rd_q[$];
  res_t        res_q[$];

  int checks = 0;
  int errors = 0;
  bit chk_stream = 1'b1;
  int since_oe = 0;
  logic done_q = 1'b0;

  // Memory model state and fault injection
  logic [7:0] mem [NADDR];
  logic       rd_p1_v = 1'b0;
  logic [7:0] rd_p1_d = 8'h00;
  bit         respond = 1'b1;
  bit         flt_on = 1'b0;
  int         flt_addr = 0;
  int         flt_bit = 0;
  bit         flt_val = 1'b0;

  function automatic logic [7:0] faulty(input logic [7:0] d, input int a);
    logic [7:0] m;
    m = 8'(1 << flt_bit);
    if (flt_on && a == flt_addr) return flt_val ? (d | m) : (d & ~m);
    return d;
  endfunction

  // Reference pattern computed directly from the pattern definitions
  function automatic logic [7:0] model_pattern(input int m, input int a, input int pc);
    logic [15:0] l;
    logic [7:0]  w;
    case (m)
      0: w = 8'(a);
      1: w = 8'((~a) & 15);
      2: begin
        l = 16'hACE1 ^ 16'(pc & 255);
        for (int k = 0; k < a; k++) l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
        w = l[7:0];
      end
      default: w = (a % 2 == 0) ? 8'h55 : 8'hAA;
    endcase
    if (pc % 2 == 1) w = ~w;
    return w;
  endfunction

  initial begin
    for (int i = 0; i < NADDR; i++) mem[i] = 8'h00;
  end

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] = mem_din;
    mem_rvalid <= rd_p1_v;
    mem_dout   <= rd_p1_d;
    rd_p1_v    <= mem_oe && respond;
    rd_p1_d    <= faulty(mem[mem_addr], int'(mem_addr));
  end

  // Slot toggles every 4 cycles, changed just after the rising edge
  initial begin
    forever begin
      repeat (4) @(posedge clk);
      #2 slot = ~slot;
    end
  end

  // Monitor: compares request stream and final results against the scoreboard
  logic [11:0] w_e;
  int          r_e;
  res_t        x_e;
  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_we || mem_oe) begin
        checks++;
        if (!slot) begin
          errors++;
          $display("FAIL slot_gate we=%0b oe=%0b slot=%0b", mem_we, mem_oe, slot);
        end
      end
      if (mem_we && chk_stream) begin
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL wr_extra got addr=%0h data=%0h expected none", mem_addr, mem_din);
        end else begin
          w_e = wr_q.pop_front();
          if ({mem_addr, mem_din} !== w_e) begin
            errors++;
            $display("FAIL wr got addr=%0h data=%0h expected addr=%0h data=%0h",
                     mem_addr, mem_din, w_e[11:8], w_e[7:0]);
          end
        end
      end
      if (mem_oe && chk_stream) begin
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL rd_extra got addr=%0h expected none", mem_addr);
        end else begin
          r_e = rd_q.pop_front();
          if (int'(mem_addr) != r_e) begin
            errors++;
            $display("FAIL rd_addr got %0h expected %0h", mem_addr, r_e);
          end
        end
      end
      since_oe = mem_oe ? 0 : since_oe + 1;
      if (done && !done_q) begin
        checks++;
        if (res_q.size() == 0) begin
          errors++;
          $display("FAIL done_extra unexpected done, none expected");
        end else begin
          x_e = res_q.pop_front();
          if ({fail, timeout, err_count, pass_count} !== {x_e.fail, x_e.timeout, x_e.err, x_e.pc}) begin
            errors++;
            $display("FAIL result got fail=%0b tmo=%0b err=%0d pc=%0d expected fail=%0b tmo=%0b err=%0d pc=%0d",
                     fail, timeout, err_count, pass_count, x_e.fail, x_e.timeout, x_e.err, x_e.pc);
          end
          checks++;
          if ({first_err_addr, first_err_got, first_err_exp} !== {x_e.fa, x_e.fg, x_e.fe}) begin
            errors++;
            $display("FAIL first_err got a=%0h g=%0h e=%0h expected a=%0h g=%0h e=%0h",
                     first_err_addr, first_err_got, first_err_exp, x_e.fa, x_e.fg, x_e.fe);
          end
          if (x_e.lat >= 0) begin
            checks++;
            if (since_oe != x_e.lat) begin
              errors++;
              $display("FAIL tmo_latency got %0d expected %0d", since_oe, x_e.lat);
            end
          end
        end
      end
      done_q = done;
    end
  end

  function automatic bit outputs_zero();
    return {mem_we, mem_oe, mem_addr, mem_din, busy, done, fail, timeout, err_count,
            first_err_addr, first_err_got, first_err_exp, pass_count} == '0;
  endfunction

  task automatic check_zero(input string name);
    checks++;
    if (!outputs_zero()) begin
      errors++;
      $display("FAIL %s outputs not all zero: busy=%0b done=%0b fail=%0b err=%0d pc=%0d we=%0b oe=%0b addr=%0h",
               name, busy, done, fail, err_count, pass_count, mem_we, mem_oe, mem_addr);
    end
  endtask

  // Build expectations from the model, start a run, and wait (bounded) for done
  task automatic run_test(input int m, input int np, input bit fon, input int faddr,
                          input int fbit, input bit fval, input bit resp, input int inj);
    res_t r;
    logic [7:0] e, g;
    int n;
    flt_on = fon; flt_addr = faddr; flt_bit = fbit; flt_val = fval; respond = resp;
    r = '{fail: 1'b0, timeout: 1'b0, err: 16'd0, pc: 8'd0, fa: 4'd0, fg: 8'd0, fe: 8'd0, lat: -1};
    if (!resp) begin
      for (int a = 0; a < NADDR; a++) wr_q.push_back({4'(a), model_pattern(m, a, 0)});
      rd_q.push_back(0);
      r.fail = 1'b1; r.timeout = 1'b1; r.lat = TMO + 2;
    end else begin
      for (int p = 0; p < np; p++) begin
        for (int a = 0; a < NADDR; a++) wr_q.push_back({4'(a), model_pattern(m, a, p)});
        for (int a = 0; a < NADDR; a++) begin
          rd_q.push_back(a);
          e = model_pattern(m, a, p);
          g = faulty(e, a);
          if (g != e) begin
            if (r.err == 16'd0) begin r.fa = 4'(a); r.fg = g; r.fe = e; end
            r.err++;
            r.fail = 1'b1;
          end
        end
      end
      r.pc = 8'(np);
    end
    res_q.push_back(r);
    @(negedge clk);
    start = 1'b1; mode = 2'(m); passes = 8'(np);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL start_busy got busy=%0b done=%0b expected busy=1 done=0", busy, done);
    end
    n = 0;
    while (!done && n < 5000) begin
      @(negedge clk);
      n++;
      start = (n == inj);
      if (n == inj) begin mode = 2'(m + 1); passes = 8'd7; end
    end
    start = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL wait_done got done=0 after %0d cycles expected done=1", n);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    logic [7:0] prev_pc;
    bit wrapped;
    repeat (3) @(negedge clk);
    check_zero("reset_hold");
    reset_n = 1'b1;
    @(negedge clk);
    check_zero("reset_release");

    run_test(0, 1, 1'b0, 0, 0, 1'b0, 1'b1, 0);
    run_test(2, 3, 1'b1, 5, 3, 1'b1, 1'b1, 0);
    for (int i = 0; i < 6; i++)
      run_test($urandom_range(0, 3), $urandom_range(1, 3), 1'($urandom_range(0, 1)),
               $urandom_range(0, 15), $urandom_range(0, 7), 1'($urandom_range(0, 1)), 1'b1, 0);
    run_test(0, 2, 1'b0, 0, 0, 1'b0, 1'b1, 20);
    run_test(1, 1, 1'b0, 0, 0, 1'b0, 1'b0, 0);

    // Endless mode-3 run: observe pass_count wrap, then reset in the middle of a read
    flt_on = 1'b0; respond = 1'b1; chk_stream = 1'b0;
    @(negedge clk);
    start = 1'b1; mode = 2'd3; passes = 8'd0;
    @(negedge clk);
    start = 1'b0;
    n = 0; wrapped = 1'b0; prev_pc = pass_count;
    while (!wrapped && n < 60000) begin
      @(negedge clk);
      n++;
      wrapped = (prev_pc == 8'hFF) && (pass_count == 8'h00);
      prev_pc = pass_count;
    end
    checks++;
    if (!wrapped || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL pc_wrap got wrapped=%0b busy=%0b done=%0b pc=%0h expected wrap to 00 with busy=1",
               wrapped, busy, done, pass_count);
    end
    n = 0;
    while (!mem_oe && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!mem_oe) begin
      errors++;
      $display("FAIL find_read got oe=0 expected a read request");
    end
    #2 reset_n = 1'b0;
    #1 check_zero("reset_mid_read");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("idle_after_reset");
    chk_stream = 1'b1;
    run_test(1, 2, 1'b0, 0, 0, 1'b0, 1'b1, 0);

    checks++;
    if (wr_q.size() != 0 || rd_q.size() != 0 || res_q.size() != 0) begin
      errors++;
      $display("FAIL queues_drained got wr=%0d rd=%0d res=%0d expected 0 0 0",
               wr_q.size(), rd_q.size(), res_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
